// File: rtl/core_pcgen_pkg.sv
// Shared types and constants for the fetch PC generator and its branch target buffer.
// The BTB itself is only built when CORE_PCGEN_BTB_EN is defined.
package core_pcgen_pkg;

  localparam logic [1:0] STRONG_NT = 2'b00;
  localparam logic [1:0] WEAK_NT   = 2'b01;
  localparam logic [1:0] WEAK_T    = 2'b10;
  localparam logic [1:0] STRONG_T  = 2'b11;

  localparam logic [31:0] DEFAULT_RESET_ADDR = 32'h0000_0000;

  // Tag/target fields are sized for the widest supported PC; narrower PCs zero-extend into them.
  localparam int BTB_FIELD_W = 64;

  typedef struct packed {
    logic                   valid;
    logic [BTB_FIELD_W-1:0] tag;
    logic [BTB_FIELD_W-1:0] target;
    logic [1:0]             ctr;
  } btb_entry_t;

  function automatic logic [1:0] ctrUpdate(input logic [1:0] ctr, input logic taken);
    if (taken) begin
      return (ctr == STRONG_T) ? STRONG_T : ctr + 2'd1;
    end
    return (ctr == STRONG_NT) ? STRONG_NT : ctr - 2'd1;
  endfunction

endpackage

// File: rtl/core_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Combinational lookup on the fetch PC, clocked update from resolved branches.
module core_btb
  import core_pcgen_pkg::*;
#(
  parameter int PC_WIDTH   = 32,
  parameter int INST_BYTES = 4,
  parameter int BTB_DEPTH  = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [PC_WIDTH-1:0] lookup_pc_i,
  output logic                pred_taken_o,
  output logic [PC_WIDTH-1:0] pred_target_o,
  input  logic                upd_valid_i,
  input  logic [PC_WIDTH-1:0] upd_pc_i,
  input  logic [PC_WIDTH-1:0] upd_target_i,
  input  logic                upd_taken_i
);

  localparam int OFF     = $clog2(INST_BYTES);
  localparam int IDX_W   = $clog2(BTB_DEPTH);
  localparam int TAG_LSB = OFF + IDX_W;
  localparam int TAG_W   = PC_WIDTH - TAG_LSB;

  btb_entry_t btb_q [BTB_DEPTH];

  logic [IDX_W-1:0] lkIdx;
  logic [IDX_W-1:0] upIdx;
  logic [TAG_W-1:0] lkTag;
  logic [TAG_W-1:0] upTag;
  btb_entry_t       lkEntry;
  btb_entry_t       upEntry;
  btb_entry_t       wrEntry;
  logic             wrEn;
  logic             unusedBits;

  assign lkIdx = lookup_pc_i[OFF +: IDX_W];
  assign lkTag = lookup_pc_i[PC_WIDTH-1:TAG_LSB];
  assign upIdx = upd_pc_i[OFF +: IDX_W];
  assign upTag = upd_pc_i[PC_WIDTH-1:TAG_LSB];

  // Lookup reads the registered array, so a same-cycle update is seen only on the next cycle.
  assign lkEntry       = btb_q[lkIdx];
  assign pred_taken_o  = lkEntry.valid && (lkEntry.tag == BTB_FIELD_W'(lkTag)) && lkEntry.ctr[1];
  assign pred_target_o = lkEntry.target[PC_WIDTH-1:0];

  assign unusedBits = ^{lookup_pc_i[OFF-1:0], upd_pc_i[OFF-1:0], lkEntry};

  always_comb begin
    upEntry = btb_q[upIdx];
    wrEntry = upEntry;
    wrEn    = 1'b0;
    if (upd_valid_i) begin
      if (upEntry.valid && (upEntry.tag == BTB_FIELD_W'(upTag))) begin
        wrEn        = 1'b1;
        wrEntry.ctr = ctrUpdate(upEntry.ctr, upd_taken_i);
        if (upd_taken_i) begin
          wrEntry.target = BTB_FIELD_W'(upd_target_i);
        end
      end else if (upd_taken_i) begin
        // A taken miss evicts whatever aliases into this slot.
        wrEn           = 1'b1;
        wrEntry.valid  = 1'b1;
        wrEntry.tag    = BTB_FIELD_W'(upTag);
        wrEntry.target = BTB_FIELD_W'(upd_target_i);
        wrEntry.ctr    = WEAK_T;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < BTB_DEPTH; i++) begin
        btb_q[i] <= '0;
      end
    end else if (wrEn) begin
      btb_q[upIdx] <= wrEntry;
    end
  end

endmodule

// File: rtl/core_pcgen_bp.sv
// Fetch PC generator: valid/ready handshake, soft-reset/trap/jump redirect priority,
// and an optional BTB predictor enabled by defining CORE_PCGEN_BTB_EN.
module core_pcgen_bp
  import core_pcgen_pkg::*;
#(
  parameter int          PC_WIDTH   = 32,
  parameter logic [31:0] RESET_ADDR = DEFAULT_RESET_ADDR,
  parameter int          INST_BYTES = 4,
  parameter int          BTB_DEPTH  = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                reset_flag_i,
  input  logic                trap_flag_i,
  input  logic [PC_WIDTH-1:0] trap_addr_i,
  input  logic                jump_flag_i,
  input  logic [PC_WIDTH-1:0] jump_addr_i,
  input  logic                hold_flag_i,
  output logic [PC_WIDTH-1:0] pc_o,
  output logic                pc_valid_o,
  input  logic                pc_ready_i,
  output logic                pred_taken_o,
  input  logic                upd_valid_i,
  input  logic [PC_WIDTH-1:0] upd_pc_i,
  input  logic [PC_WIDTH-1:0] upd_target_i,
  input  logic                upd_taken_i
);

  localparam logic [PC_WIDTH-1:0] RST_PC = PC_WIDTH'(RESET_ADDR);

  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_d;
  logic                pcValid_q;
  logic [PC_WIDTH-1:0] seqPc;
  logic [PC_WIDTH-1:0] predPc;

  assign seqPc = pc_q + PC_WIDTH'(INST_BYTES);

`ifdef CORE_PCGEN_BTB_EN
  logic                btbTaken;
  logic [PC_WIDTH-1:0] btbTarget;

  core_btb #(
    .PC_WIDTH   (PC_WIDTH),
    .INST_BYTES (INST_BYTES),
    .BTB_DEPTH  (BTB_DEPTH)
  ) u_btb (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .lookup_pc_i   (pc_q),
    .pred_taken_o  (btbTaken),
    .pred_target_o (btbTarget),
    .upd_valid_i   (upd_valid_i),
    .upd_pc_i      (upd_pc_i),
    .upd_target_i  (upd_target_i),
    .upd_taken_i   (upd_taken_i)
  );

  assign pred_taken_o = btbTaken;
  assign predPc       = btbTaken ? btbTarget : seqPc;
`else
  logic unusedUpd;

  assign unusedUpd    = ^{upd_valid_i, upd_pc_i, upd_target_i, upd_taken_i};
  assign pred_taken_o = 1'b0;
  assign predPc       = seqPc;
`endif

  // Redirects win over stalls and the handshake; the first cycle after reset only raises valid.
  always_comb begin
    pc_d = pc_q;
    if (pcValid_q) begin
      if (reset_flag_i) begin
        pc_d = RST_PC;
      end else if (trap_flag_i) begin
        pc_d = trap_addr_i;
      end else if (jump_flag_i) begin
        pc_d = jump_addr_i;
      end else if (hold_flag_i) begin
        pc_d = pc_q;
      end else if (pc_ready_i) begin
        pc_d = predPc;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q      <= RST_PC;
      pcValid_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      pcValid_q <= 1'b1;
    end
  end

  assign pc_o       = pc_q;
  assign pc_valid_o = pcValid_q;

endmodule

// File: tb/tb_core_pcgen_bp.sv
// Directed bench for core_pcgen_bp: a 32-bit instance for handshake, redirects and the BTB,
// plus a 16-bit instance for the wrap-around case. BTB expectations follow CORE_PCGEN_BTB_EN.
module tb_core_pcgen_bp;

`ifdef CORE_PCGEN_BTB_EN
  localparam bit BTB_ON = 1'b1;
`else
  localparam bit BTB_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        resetFlag;
  logic        trapFlag;
  logic [31:0] trapAddr;
  logic        jumpFlag;
  logic [31:0] jumpAddr;
  logic        holdFlag;
  logic [31:0] pc;
  logic        pcValid;
  logic        pcReady;
  logic        predTaken;
  logic        updValid;
  logic [31:0] updPc;
  logic [31:0] updTarget;
  logic        updTaken;

  logic        jumpFlag16;
  logic [15:0] jumpAddr16;
  logic [15:0] pc16;
  logic        pcValid16;
  logic        pcReady16;
  logic        predTaken16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  core_pcgen_bp dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .reset_flag_i (resetFlag),
    .trap_flag_i  (trapFlag),
    .trap_addr_i  (trapAddr),
    .jump_flag_i  (jumpFlag),
    .jump_addr_i  (jumpAddr),
    .hold_flag_i  (holdFlag),
    .pc_o         (pc),
    .pc_valid_o   (pcValid),
    .pc_ready_i   (pcReady),
    .pred_taken_o (predTaken),
    .upd_valid_i  (updValid),
    .upd_pc_i     (updPc),
    .upd_target_i (updTarget),
    .upd_taken_i  (updTaken)
  );

  core_pcgen_bp #(.PC_WIDTH(16)) dut16 (
    .clk_i        (clk),
    .rst_i        (rst),
    .reset_flag_i (1'b0),
    .trap_flag_i  (1'b0),
    .trap_addr_i  (16'h0000),
    .jump_flag_i  (jumpFlag16),
    .jump_addr_i  (jumpAddr16),
    .hold_flag_i  (1'b0),
    .pc_o         (pc16),
    .pc_valid_o   (pcValid16),
    .pc_ready_i   (pcReady16),
    .pred_taken_o (predTaken16),
    .upd_valid_i  (1'b0),
    .upd_pc_i     (16'h0000),
    .upd_target_i (16'h0000),
    .upd_taken_i  (1'b0)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      $error("[TB] check %s observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive the redirect/handshake inputs, then step one clock and settle past the edge.
  task automatic applyStimulus(input logic rf, input logic tf, input logic [31:0] ta,
                               input logic jf, input logic [31:0] ja, input logic hf, input logic rdy);
    resetFlag = rf;
    trapFlag  = tf;
    trapAddr  = ta;
    jumpFlag  = jf;
    jumpAddr  = ja;
    holdFlag  = hf;
    pcReady   = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic applyUpdate(input logic [31:0] bpc, input logic [31:0] tgt, input logic taken);
    updValid  = 1'b1;
    updPc     = bpc;
    updTarget = tgt;
    updTaken  = taken;
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    updValid  = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    resetFlag = 0; trapFlag = 0; trapAddr = 0; jumpFlag = 0; jumpAddr = 0; holdFlag = 0;
    pcReady = 1'b1; updValid = 0; updPc = 0; updTarget = 0; updTaken = 0;
    jumpFlag16 = 0; jumpAddr16 = 0; pcReady16 = 0;
    #3;
    checkOutput("rst_pc", pc, 32'h0);
    checkOutput("rst_valid", {31'b0, pcValid}, 32'h0);
    checkOutput("rst_pred", {31'b0, predTaken}, 32'h0);
    checkOutput("rst_valid16", {31'b0, pcValid16}, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("rst_hold_valid", {31'b0, pcValid}, 32'h0);
    rst = 1'b0;

    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("rel_valid", {31'b0, pcValid}, 32'h1);
    checkOutput("rel_pc", pc, 32'h0);
    checkOutput("rel_valid16", {31'b0, pcValid16}, 32'h1);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("seq_4", pc, 32'h4);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("seq_8", pc, 32'h8);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("seq_c", pc, 32'hC);
    checkOutput("seq_pred", {31'b0, predTaken}, 32'h0);

    applyStimulus(0, 0, 0, 1, 32'h20, 0, 1);
    checkOutput("jump_20", pc, 32'h20);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 0, 0, 0, 0, 0);
      checkOutput("stall_pc", pc, 32'h20);
      checkOutput("stall_valid", {31'b0, pcValid}, 32'h1);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("stall_release", pc, 32'h24);

    applyStimulus(0, 0, 0, 1, 32'h100, 1, 1);
    checkOutput("jump_over_hold", pc, 32'h100);
    applyStimulus(0, 0, 0, 0, 0, 1, 1);
    checkOutput("hold_pc", pc, 32'h100);
    applyStimulus(0, 1, 32'h80, 1, 32'h100, 0, 1);
    checkOutput("trap_over_jump", pc, 32'h80);

    jumpFlag16 = 1'b1;
    jumpAddr16 = 16'hFFFC;
    applyStimulus(1, 1, 32'h80, 1, 32'h300, 0, 1);
    checkOutput("soft_reset", pc, 32'h0);
    checkOutput("pc16_fffc", {16'h0, pc16}, 32'h0000_FFFC);
    jumpFlag16 = 1'b0;
    pcReady16  = 1'b1;
    applyUpdate(32'h40, 32'h200, 1'b1);
    checkOutput("upd_hold_pc", pc, 32'h0);
    checkOutput("pc16_wrap", {16'h0, pc16}, 32'h0);
    checkOutput("pred16", {31'b0, predTaken16}, 32'h0);
    pcReady16 = 1'b0;

    applyStimulus(0, 0, 0, 1, 32'h40, 0, 1);
    checkOutput("btb_pred_40", {31'b0, predTaken}, {31'b0, BTB_ON});
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("btb_next_40", pc, BTB_ON ? 32'h200 : 32'h44);
    applyUpdate(32'h40, 32'h200, 1'b0);
    applyUpdate(32'h40, 32'h200, 1'b0);
    applyStimulus(0, 0, 0, 1, 32'h40, 0, 1);
    checkOutput("btb_nt_pred", {31'b0, predTaken}, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("btb_nt_next", pc, 32'h44);

    applyUpdate(32'h40, 32'h200, 1'b1);
    applyUpdate(32'h40, 32'h200, 1'b1);
    applyStimulus(0, 0, 0, 1, 32'h40, 0, 1);
    checkOutput("btb_retrain", {31'b0, predTaken}, {31'b0, BTB_ON});
    applyUpdate(32'h60, 32'h300, 1'b1);
    checkOutput("alias_pred_40", {31'b0, predTaken}, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("alias_next_40", pc, 32'h44);
    applyStimulus(0, 0, 0, 1, 32'h60, 0, 1);
    checkOutput("alias_pred_60", {31'b0, predTaken}, {31'b0, BTB_ON});

    updValid = 1'b1; updPc = 32'h60; updTarget = 32'h300; updTaken = 1'b0;
    #1;
    checkOutput("same_cycle_old", {31'b0, predTaken}, {31'b0, BTB_ON});
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    updValid = 1'b0;
    checkOutput("same_cycle_new", {31'b0, predTaken}, 32'h0);
    checkOutput("same_cycle_pc", pc, 32'h60);

    applyUpdate(32'h60, 32'h300, 1'b1);
    applyStimulus(1, 0, 0, 0, 0, 0, 1);
    checkOutput("soft_rst_pc", pc, 32'h0);
    applyStimulus(0, 0, 0, 1, 32'h60, 0, 1);
    checkOutput("soft_keeps_btb", {31'b0, predTaken}, {31'b0, BTB_ON});
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("soft_keeps_next", pc, BTB_ON ? 32'h300 : 32'h64);

    rst = 1'b1;
    #1;
    checkOutput("hw_rst_pc", pc, 32'h0);
    checkOutput("hw_rst_valid", {31'b0, pcValid}, 32'h0);
    applyStimulus(0, 0, 0, 1, 32'h60, 0, 1);
    checkOutput("hw_rst_hold", pc, 32'h0);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 1, 32'h60, 0, 1);
    checkOutput("hw_rel_pc", pc, 32'h0);
    checkOutput("hw_rel_valid", {31'b0, pcValid}, 32'h1);
    applyStimulus(0, 0, 0, 1, 32'h60, 0, 1);
    checkOutput("hw_btb_clear", {31'b0, predTaken}, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1);
    checkOutput("hw_btb_next", pc, 32'h64);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_pcgen_bp.md
# core_pcgen_bp

Parametrised program-counter generator for the fetch stage. It adds a valid/ready fetch handshake, a three-level redirect priority (soft reset, trap, jump), and an optional direct-mapped branch target buffer (BTB) with 2-bit saturating counters. It drives the PC to the instruction memory interface and receives resolved branch outcomes from execute.

## Interface
Parameters:
- PC_WIDTH, 32, PC and address width in bits.
- RESET_ADDR, 32'h0000_0000, PC loaded on hardware or soft reset. Truncated to PC_WIDTH.
- INST_BYTES, 4, sequential increment; 2 or 4 only.
- BTB_DEPTH, 8, number of BTB entries; power of two, ≥2.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  asynchronous, active-high hardware reset
- reset_flag_i  in  1  soft reset request
- trap_flag_i  in  1  trap redirect request
- trap_addr_i  in  PC_WIDTH  trap vector
- jump_flag_i  in  1  resolved jump/mispredict redirect
- jump_addr_i  in  PC_WIDTH  jump target
- hold_flag_i  in  1  pipeline stall
- pc_o  out  PC_WIDTH  current fetch PC
- pc_valid_o  out  1  pc_o offered to fetch
- pc_ready_i  in  1  fetch accepts pc_o
- pred_taken_o  out  1  pc_o predicted taken (BTB hit, counter ≥ 2)
- upd_valid_i  in  1  branch outcome update strobe
- upd_pc_i  in  PC_WIDTH  PC of the resolved branch
- upd_target_i  in  PC_WIDTH  resolved target
- upd_taken_i  in  1  branch was taken

## Operation
- Hardware reset (rst_i=1, async): pc_o=RESET_ADDR, pc_valid_o=0, all BTB valid bits cleared. pred_taken_o follows the BTB and is therefore 0.
- First rising edge after rst_i falls sets pc_valid_o=1 and leaves pc_o unchanged. pc_valid_o then stays 1 until the next hardware reset.
- Next-PC priority, evaluated each edge with pc_valid_o=1:
  1. reset_flag_i → RESET_ADDR
  2. trap_flag_i → trap_addr_i
  3. jump_flag_i → jump_addr_i
  4. hold_flag_i → hold pc_o
  5. pc_ready_i → predicted next PC
  6. otherwise → hold
- A redirect ignores pc_ready_i and hold_flag_i. The currently offered PC is dropped.
- Predicted next PC is upd-independent: if pred_taken_o, the BTB target; else pc_o+INST_BYTES, modulo 2^PC_WIDTH (wraps to 0).
- Redirect addresses are loaded unmodified; alignment is the producer's responsibility.
- BTB geometry:
  - OFF = log2(INST_BYTES); IDX_W = log2(BTB_DEPTH).
  - index = pc[OFF +: IDX_W]; tag = pc[PC_WIDTH-1 : OFF+IDX_W].
  - Entry fields: valid, tag, target, ctr[1:0].
- Lookup is combinational on pc_o. pred_taken_o = valid & tag match & ctr[1].
- Update on upd_valid_i (clocked):
  - Tag hit: ctr saturates up if taken, down if not taken. Target is overwritten only when taken.
  - Miss and taken: allocate with valid=1, new tag, target, ctr=2'b10. Any existing entry at that index is replaced.
  - Miss and not taken: no change.
- Lookup and update at the same index in the same cycle: lookup sees pre-update contents. The update is visible the next cycle.
- Soft reset (reset_flag_i) does not clear the BTB.

## Timing
- All state changes occur on the rising edge of clk_i, except asynchronous hardware reset.
- A redirect asserted in cycle N: pc_o shows the target in N+1, pc_valid_o=1.
- Accepted handshake in cycle N (valid & ready & no hold/redirect): new pc_o in N+1. Sustained throughput is one PC per cycle.
- pc_o and pc_valid_o are stable while pc_valid_o=1 and pc_ready_i=0.
- BTB update in cycle N affects pred_taken_o from N+1.
- rst_i asserted mid-operation: outputs return to reset values immediately. Pending updates are lost.

## Configuration
- CORE_PCGEN_BTB_EN defined: BTB instantiated as above.
- CORE_PCGEN_BTB_EN undefined:
  - No BTB storage.
  - pred_taken_o tied 0.
  - upd_* inputs ignored.
  - Next PC is always pc_o+INST_BYTES.
  - Handshake and redirect behaviour unchanged.

## Structure
- Shared package core_pcgen_pkg: counter encodings (STRONG_NT=2'b00, WEAK_NT=2'b01, WEAK_T=2'b10, STRONG_T=2'b11), the default reset address constant, and the BTB entry struct typedef.
- Sub-module core_btb: storage, lookup and update, parametrised by PC_WIDTH, INST_BYTES, BTB_DEPTH. It is instantiated only under CORE_PCGEN_BTB_EN.
- Top level holds the PC register, valid flag, and priority mux.

## Test plan
- Reset release, pc_ready_i=1, no redirects → pc_valid_o rises one cycle after release; pc_o sequence 0x0, 0x4, 0x8, 0xC.
- jump_flag_i=1, jump_addr_i=0x100, with hold_flag_i=1 and reset_flag_i=0 in the same cycle → pc_o=0x100 next cycle. Repeat with trap_flag_i=1, trap_addr_i=0x80 and reset_flag_i=1 together → pc_o=RESET_ADDR.
- pc_ready_i=0 for 3 cycles at pc_o=0x20 → pc_o stays 0x20. When ready returns to 1 → 0x24.
- PC_WIDTH=16, pc_o=0xFFFC, accepted → pc_o=0x0000.
- With BTB: update pc=0x40, target=0x200, taken → at pc_o=0x40, pred_taken_o=1 and next pc_o=0x200. Two not-taken updates → pred_taken_o=0, next pc_o=0x44.
- Aliasing with BTB_DEPTH=8: entry for 0x40 present, taken update at 0x60 (same index, different tag) → 0x60 replaces it; lookup at 0x40 then predicts not taken.
